// File: rtl/if_fetch_pipe.sv
// if_fetch_pipe -- instruction fetch stage with a one-entry skid buffer.
//
// Fetches one word per cycle from instruction memory into the IF/ID
// register. When decode back-pressures while a fetch returns, the returned
// word is parked in a skid buffer and the FSM waits in STALL until decode
// drains IF/ID. A taken branch redirects the PC, flushes IF/ID and the skid
// buffer, and drops whatever memory returns in that cycle.
//
// Optional feature macro: FETCH_PERF_EN
//   defined   -> fetch_cnt / stall_cnt are live 32-bit wrapping counters
//   undefined -> both outputs are tied to zero and no counter logic exists
//
// Reset: 'start' is an asynchronous active-low reset (0 = reset, 1 = run).

module if_fetch_pipe #(
  parameter int               width    = 32,
  parameter logic [width-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             start,
  // Instruction memory interface
  output logic             imem_req,
  output logic [width-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [width-1:0] imem_rdata,
  // Redirect from execute
  input  logic             branch_taken,
  input  logic [width-1:0] branch_target,
  // IF/ID pipeline register towards decode
  input  logic             id_ready,
  output logic             if_id_valid,
  output logic [width-1:0] if_id_inst,
  output logic [width-1:0] if_id_pc,
  output logic [width-1:0] if_id_pc_plus4,
  // Performance counters
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt
);

  localparam logic [width-1:0] PC_STEP          = width'(4);
  localparam logic [width-1:0] ALIGN_MASK       = ~width'(3);
  localparam logic [width-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Architectural state
  logic [width-1:0] r_pc;
  logic             r_if_id_valid;
  logic [width-1:0] r_if_id_inst;
  logic [width-1:0] r_if_id_pc;
  logic [width-1:0] r_if_id_pc_plus4;
  // Skid buffer; it holds a live entry exactly when the FSM is in STALL.
  logic [width-1:0] r_skid_inst;
  logic [width-1:0] r_skid_pc;

  // Per-cycle control decoded by the FSM
  logic w_redirect;     // branch wins: reload pc, flush everything
  logic w_load_if_id;   // memory word goes straight into IF/ID
  logic w_load_skid;    // memory word parked in the skid buffer
  logic w_unload_skid;  // skid buffer moves into IF/ID
  logic w_clear_valid;  // decode took IF/ID and nothing replaces it

  logic [width-1:0] w_pc_plus4;
  logic [width-1:0] w_skid_pc_plus4;
  logic [width-1:0] w_target_aligned;

  assign w_pc_plus4       = r_pc + PC_STEP;        // wraps mod 2^width
  assign w_skid_pc_plus4  = r_skid_pc + PC_STEP;
  assign w_target_aligned = branch_target & ALIGN_MASK;

  assign imem_addr      = r_pc;
  assign if_id_valid    = r_if_id_valid;
  assign if_id_inst     = r_if_id_inst;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;

  // FSM state register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge start) begin
    if (!start) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state, memory request and datapath control decode.
  // NOTE: every signal written here gets a default first so that no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    w_state_next  = r_state;
    imem_req      = 1'b0;
    w_redirect    = 1'b0;
    w_load_if_id  = 1'b0;
    w_load_skid   = 1'b0;
    w_unload_skid = 1'b0;
    w_clear_valid = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          w_redirect   = 1'b1;
          w_state_next = FETCH;
        end else if (imem_ready) begin
          if (!r_if_id_valid || id_ready) begin
            w_load_if_id = 1'b1;
          end else begin
            w_load_skid  = 1'b1;
            w_state_next = STALL;
          end
        end else if (r_if_id_valid && id_ready) begin
          w_clear_valid = 1'b1;
        end
      end

      STALL: begin
        if (branch_taken) begin
          w_redirect   = 1'b1;
          w_state_next = FETCH;
        end else if (id_ready) begin
          w_unload_skid = 1'b1;
          w_state_next  = FETCH;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // PC, IF/ID register and skid buffer update.
  // NOTE: the data registers (IF/ID payload and skid) are reset too, so the
  // outputs read as zero out of reset rather than X; valid alone qualifies them.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_pc             <= RESET_PC_ALIGNED;
      r_if_id_valid    <= 1'b0;
      r_if_id_inst     <= '0;
      r_if_id_pc       <= '0;
      r_if_id_pc_plus4 <= '0;
      r_skid_inst      <= '0;
      r_skid_pc        <= '0;
    end else if (w_redirect) begin
      // Payload stays put; only valid drops. Skid contents become stale
      // because the FSM leaves STALL.
      r_pc          <= w_target_aligned;
      r_if_id_valid <= 1'b0;
    end else begin
      if (w_load_if_id || w_load_skid) begin
        r_pc <= w_pc_plus4;
      end
      if (w_load_if_id) begin
        r_if_id_valid    <= 1'b1;
        r_if_id_inst     <= imem_rdata;
        r_if_id_pc       <= r_pc;
        r_if_id_pc_plus4 <= w_pc_plus4;
      end
      if (w_load_skid) begin
        r_skid_inst <= imem_rdata;
        r_skid_pc   <= r_pc;
      end
      if (w_unload_skid) begin
        r_if_id_valid    <= 1'b1;
        r_if_id_inst     <= r_skid_inst;
        r_if_id_pc       <= r_skid_pc;
        r_if_id_pc_plus4 <= w_skid_pc_plus4;
      end
      if (w_clear_valid) begin
        r_if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_fetch_event;
  logic        w_stall_cycle;

  // A fetch counts when memory data is accepted into IF/ID or the skid;
  // data dropped by a same-cycle redirect never sets these strobes.
  assign w_fetch_event = w_load_if_id | w_load_skid;
  assign w_stall_cycle = (r_state == STALL) ||
                         ((r_state == FETCH) && !imem_ready);

  // Wrapping performance counters.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch_event) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_cycle) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_pipe.sv
// tb_if_fetch_pipe -- self-checking bench for if_fetch_pipe.
// Expected IF/ID transfers are pushed to a scoreboard queue as stimulus is
// set up and popped when decode accepts an instruction; directed tasks add
// inline checks of addresses, stalls, redirects, reset and counters.

module tb_if_fetch_pipe;

  localparam int          W        = 32;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
`ifdef FETCH_PERF_EN
  localparam bit          PERF     = 1'b1;
`else
  localparam bit          PERF     = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          start;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ready;
  logic [W-1:0]  imem_rdata;
  logic          branch_taken;
  logic [W-1:0]  branch_target;
  logic          id_ready;
  logic          if_id_valid;
  logic [W-1:0]  if_id_inst;
  logic [W-1:0]  if_id_pc;
  logic [W-1:0]  if_id_pc_plus4;
  logic [31:0]   fetch_cnt;
  logic [31:0]   stall_cnt;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_xfer   = 0;
  logic [31:0]   sb_q[$];

  if_fetch_pipe #(.width(W), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .start          (start),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  // Garbage on the bus while not ready, so a premature load shows up.
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_DEAD;

  // One clock: at the falling edge, compare any IF/ID instruction decode is
  // about to accept against the scoreboard; then advance past the rising edge.
  task automatic step();
    logic [31:0] exp_pc;
    @(negedge clk);
    if (start && if_id_valid && id_ready && !branch_taken) begin
      n_xfer++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underflow: got transfer of pc=%h, required none", if_id_pc);
      end else begin
        exp_pc = sb_q.pop_front();
        if (if_id_pc !== exp_pc) begin
          n_errors++;
          $display("FAIL sb_pc: got %h required %h", if_id_pc, exp_pc);
        end
        n_checks++;
        if (if_id_inst !== mem_word(exp_pc)) begin
          n_errors++;
          $display("FAIL sb_inst: got %h required %h", if_id_inst, mem_word(exp_pc));
        end
        n_checks++;
        if (if_id_pc_plus4 !== exp_pc + 32'd4) begin
          n_errors++;
          $display("FAIL sb_pc_plus4: got %h required %h", if_id_pc_plus4, exp_pc + 32'd4);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_ready    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    id_ready      = 1'b0;
    start         = 1'b0;
    #2;
    sb_q.delete();
    start = 1'b1;
  endtask

  task automatic check_sb_empty(input string name);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: got %0d pending scoreboard entries, required 0", name, sb_q.size());
    end
  endtask

  // Reset values, then IDLE for one cycle before the first request.
  task automatic test_reset();
    imem_ready = 1'b0; branch_taken = 1'b0; branch_target = '0; id_ready = 1'b0;
    start = 1'b0;
    #2;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
    n_checks++; if (imem_addr !== RST_PC) begin n_errors++; $display("FAIL rst_addr: got %h required %h", imem_addr, RST_PC); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b required 0", if_id_valid); end
    n_checks++; if (if_id_inst !== 32'h0) begin n_errors++; $display("FAIL rst_inst: got %h required 0", if_id_inst); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_errors++; $display("FAIL rst_pc: got %h required 0", if_id_pc); end
    n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_errors++; $display("FAIL rst_pc4: got %h required 0", if_id_pc_plus4); end
    n_checks++; if (fetch_cnt !== 32'h0) begin n_errors++; $display("FAIL rst_fcnt: got %0d required 0", fetch_cnt); end
    n_checks++; if (stall_cnt !== 32'h0) begin n_errors++; $display("FAIL rst_scnt: got %0d required 0", stall_cnt); end
    start = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL idle_req: got %b required 0", imem_req); end
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL fetch_req: got %b required 1", imem_req); end
  endtask

  // Four back-to-back fetches with no back-pressure.
  task automatic test_stream();
    do_reset();
    step();
    n_checks++; if (imem_addr !== RST_PC) begin n_errors++; $display("FAIL stream_first_addr: got %h required %h", imem_addr, RST_PC); end
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (imem_addr !== 32'(i * 4)) begin n_errors++; $display("FAIL stream_addr%0d: got %h required %h", i, imem_addr, 32'(i * 4)); end
      sb_q.push_back(32'(i * 4));
      step();
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(i * 4)) begin
        n_errors++;
        $display("FAIL stream_ifid%0d: got valid=%b pc=%h required valid=1 pc=%h", i, if_id_valid, if_id_pc, 32'(i * 4));
      end
    end
    n_checks++; if (fetch_cnt !== (PERF ? 32'd4 : 32'd0)) begin n_errors++; $display("FAIL stream_fcnt: got %0d required %0d", fetch_cnt, PERF ? 4 : 0); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL stream_scnt: got %0d required 0", stall_cnt); end
  endtask

  // Memory not ready for three cycles at 0x10 (continues from test_stream).
  task automatic test_imem_wait();
    imem_ready = 1'b0;
    id_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
        n_errors++;
        $display("FAIL wait_addr%0d: got req=%b addr=%h required req=1 addr=00000010", i, imem_req, imem_addr);
      end
      if (i == 0) begin
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'hC) begin
          n_errors++;
          $display("FAIL wait_drain: got valid=%b pc=%h required valid=0 pc=0000000c", if_id_valid, if_id_pc);
        end
      end
    end
    n_checks++; if (stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_errors++; $display("FAIL wait_scnt: got %0d required %0d", stall_cnt, PERF ? 3 : 0); end
    imem_ready = 1'b1;
    sb_q.push_back(32'h10);
    step();
    n_checks++; if (if_id_pc !== 32'h10 || if_id_valid !== 1'b1) begin n_errors++; $display("FAIL wait_resume: got valid=%b pc=%h required valid=1 pc=00000010", if_id_valid, if_id_pc); end
    imem_ready = 1'b0;
    step();
    check_sb_empty("wait_sb_empty");
  endtask

  // Decode stalls with if_id_pc=4 while address 8 returns.
  task automatic test_stall();
    do_reset();
    step();
    imem_ready = 1'b1; id_ready = 1'b1;
    sb_q.push_back(32'h0); step();
    sb_q.push_back(32'h4); step();
    id_ready = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req: got %b required 0", imem_req); end
    n_checks++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin n_errors++; $display("FAIL stall_ifid: got valid=%b pc=%h required valid=1 pc=00000004", if_id_valid, if_id_pc); end
    n_checks++; if (imem_addr !== 32'hC) begin n_errors++; $display("FAIL stall_addr: got %h required 0000000c", imem_addr); end
    step();
    n_checks++; if (imem_req !== 1'b0 || if_id_inst !== mem_word(32'h4)) begin n_errors++; $display("FAIL stall_hold: got req=%b inst=%h required req=0 inst=%h", imem_req, if_id_inst, mem_word(32'h4)); end
    sb_q.push_back(32'h8);
    id_ready = 1'b1;
    step();
    n_checks++; if (if_id_pc !== 32'h8 || if_id_inst !== mem_word(32'h8)) begin n_errors++; $display("FAIL unstall_ifid: got pc=%h inst=%h required pc=00000008 inst=%h", if_id_pc, if_id_inst, mem_word(32'h8)); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_errors++; $display("FAIL unstall_req: got req=%b addr=%h required req=1 addr=0000000c", imem_req, imem_addr); end
    n_checks++; if (stall_cnt !== (PERF ? 32'd2 : 32'd0)) begin n_errors++; $display("FAIL stall_scnt: got %0d required %0d", stall_cnt, PERF ? 2 : 0); end
    n_checks++; if (fetch_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_errors++; $display("FAIL stall_fcnt: got %0d required %0d", fetch_cnt, PERF ? 3 : 0); end
    imem_ready = 1'b0;
    step();
    check_sb_empty("stall_sb_empty");
  endtask

  // Redirect to 0x102 while in STALL: skid entry discarded.
  task automatic test_branch_in_stall();
    do_reset();
    step();
    imem_ready = 1'b1; id_ready = 1'b1;
    sb_q.push_back(32'h0); step();
    step();                              // if_id <= 4, flushed later
    id_ready = 1'b0;
    step();                              // STALL, skid holds 8
    branch_taken = 1'b1; branch_target = 32'h102;
    step();
    n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL br_valid: got %b required 0", if_id_valid); end
    n_checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_errors++; $display("FAIL br_addr: got req=%b addr=%h required req=1 addr=00000100", imem_req, imem_addr); end
    n_checks++; if (if_id_pc !== 32'h4) begin n_errors++; $display("FAIL br_data_kept: got pc=%h required 00000004", if_id_pc); end
    branch_taken = 1'b0; id_ready = 1'b1;
    sb_q.push_back(32'h100);
    step();
    n_checks++; if (if_id_pc !== 32'h100 || if_id_inst !== mem_word(32'h100)) begin n_errors++; $display("FAIL br_target_ifid: got pc=%h inst=%h required pc=00000100 inst=%h", if_id_pc, if_id_inst, mem_word(32'h100)); end
    n_checks++; if (imem_addr !== 32'h104) begin n_errors++; $display("FAIL br_next_addr: got %h required 00000104", imem_addr); end
    imem_ready = 1'b0;
    step();
    check_sb_empty("br_sb_empty");
  endtask

  // Asynchronous reset in the middle of STALL.
  task automatic test_reset_mid_stall();
    do_reset();
    step();
    imem_ready = 1'b1; id_ready = 1'b1;
    sb_q.push_back(32'h0); step();
    step();
    id_ready = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'hC) begin n_errors++; $display("FAIL mid_pre: got req=%b addr=%h required req=0 addr=0000000c", imem_req, imem_addr); end
    #2;
    start = 1'b0;
    #1;
    n_checks++; if (imem_addr !== RST_PC || imem_req !== 1'b0) begin n_errors++; $display("FAIL mid_rst_addr: got req=%b addr=%h required req=0 addr=%h", imem_req, imem_addr, RST_PC); end
    n_checks++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_inst !== 32'h0) begin n_errors++; $display("FAIL mid_rst_ifid: got valid=%b pc=%h inst=%h required all 0", if_id_valid, if_id_pc, if_id_inst); end
    n_checks++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin n_errors++; $display("FAIL mid_rst_cnt: got f=%0d s=%0d required 0 0", fetch_cnt, stall_cnt); end
    sb_q.delete();
    imem_ready = 1'b0; id_ready = 1'b0;
    start = 1'b1;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_errors++; $display("FAIL mid_restart: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RST_PC); end
  endtask

  // PC wraps from 0xFFFF_FFFC to 0 (continues in FETCH).
  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_align: got %h required fffffffc", imem_addr); end
    branch_taken = 1'b0; imem_ready = 1'b1; id_ready = 1'b1;
    sb_q.push_back(32'hFFFF_FFFC);
    step();
    n_checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0) begin n_errors++; $display("FAIL wrap_ifid: got pc=%h pc4=%h required fffffffc 00000000", if_id_pc, if_id_pc_plus4); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr: got %h required 00000000", imem_addr); end
    sb_q.push_back(32'h0);
    step();
    n_checks++; if (if_id_pc !== 32'h0) begin n_errors++; $display("FAIL wrap_next: got %h required 00000000", if_id_pc); end
    imem_ready = 1'b0;
    step();
    check_sb_empty("wrap_sb_empty");
  endtask

  // Random memory/decode back-pressure; order must be strictly sequential.
  task automatic test_back_to_back();
    localparam int N = 24;
    do_reset();
    step();
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < N + 4; i++) sb_q.push_back(32'h200 + 32'(i * 4));
    n_xfer = 0;
    for (int c = 0; c < 600; c++) begin
      if (n_xfer >= N) break;
      imem_ready = 1'($urandom_range(0, 1));
      id_ready   = 1'($urandom_range(0, 1));
      step();
    end
    imem_ready = 1'b0; id_ready = 1'b0;
    n_checks++; if (n_xfer < N) begin n_errors++; $display("FAIL b2b_timeout: got %0d transfers required %0d", n_xfer, N); end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_imem_wait();
    test_stall();
    test_branch_in_stall();
    test_reset_mid_stall();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
